// File: rtl/beep_seq_pkg.sv
// Shared types and constants for the beep sequencer: FSM states, note codes and the
// note-code to PWM-period table.
package beep_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PLAY,
    ST_GAP
  } state_t;

  typedef logic [3:0] note_t;

  localparam note_t NOTE_REST = 4'd0;

  // Codes 1..7 are C5..B5, 8..11 are system beep classes, the rest are silent
  localparam logic [31:0] NOTE_PERIOD [16] = '{
    32'd0,      32'd191113, 32'd170262, 32'd151686,
    32'd143173, 32'd127551, 32'd113636, 32'd101239,
    32'd100000, 32'd50000,  32'd25000,  32'd12500,
    32'd0,      32'd0,      32'd0,      32'd0
  };

  function automatic logic is_rest(input note_t code);
    return (code == NOTE_REST) || (code >= 4'd12);
  endfunction

endpackage

// File: rtl/beep_seq_if.sv
// Request/tone bundle between control logic (master) and beep_sequencer (slave).
// req_urgent exists only when BEEP_SEQ_PREEMPT_EN is defined.
interface beep_seq_if #(
  parameter int FIFO_DEPTH = 4
) ();
  import beep_seq_pkg::*;

  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  logic               req_valid;
  logic               req_ready;
  note_t              req_note;
  logic [7:0]         req_dur;
  logic               flush;
`ifdef BEEP_SEQ_PREEMPT_EN
  logic               req_urgent;
`endif
  logic               tone_en;
  logic [31:0]        tone_period;
  logic               busy;
  logic [LEVEL_W-1:0] fifo_level;

  modport master (
    output req_valid, req_note, req_dur, flush,
`ifdef BEEP_SEQ_PREEMPT_EN
    output req_urgent,
`endif
    input  req_ready, tone_en, tone_period, busy, fifo_level
  );

  modport slave (
    input  req_valid, req_note, req_dur, flush,
`ifdef BEEP_SEQ_PREEMPT_EN
    input  req_urgent,
`endif
    output req_ready, tone_en, tone_period, busy, fifo_level
  );

endinterface

// File: rtl/beep_seq_fifo.sv
// Synchronous request FIFO with flush, occupancy level and same-cycle push/pop.
// replace turns a push into "drop everything, keep only this entry".
module beep_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   replace,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    wr_idx;

  assign wr_idx = replace ? '0 : wr_ptr;
  assign rdata  = mem[rd_ptr];
  assign full   = (level == (AW+1)'(DEPTH));
  assign empty  = (level == '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_idx] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else if (replace && push) begin
      rd_ptr <= '0;
      wr_ptr <= AW'(1);
      level  <= (AW+1)'(1);
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/beep_sequencer.sv
// Queued tone-request sequencer feeding the speaker PWM stage: buffers note requests,
// plays them one at a time with a silent gap. Define BEEP_SEQ_PREEMPT_EN for urgent preemption.
module beep_sequencer
  import beep_seq_pkg::*;
#(
  parameter int TICK_CYCLES = 1_000_000,
  parameter int FIFO_DEPTH  = 4,
  parameter int GAP_TICKS   = 2
) (
  input  logic      clk,
  input  logic      rst,
  beep_seq_if.slave bus
);
  localparam int                 AW         = $clog2(FIFO_DEPTH);
  localparam int                 PRESC_W    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_CYCLES - 1);
  localparam logic [7:0]         GAP_COUNT  = 8'(GAP_TICKS);

  state_t             state;
  state_t             state_next;
  logic [PRESC_W-1:0] presc;
  logic [7:0]         tick_cnt;
  note_t              cur_note;
  logic [7:0]         cur_dur;
  logic [31:0]        period_q;
  logic [11:0]        fifo_rdata;
  logic [AW:0]        fifo_level;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               urgent_push;
  logic               tick;
  logic               last_tick;
  logic               load_play;
  logic               load_gap;
  logic               tone_en;

  // Ready is forced high in reset so upstream never sees a stalled queue while it is held
  assign bus.req_ready = !rst || (!fifo_full && !bus.flush);
  assign push          = bus.req_valid && bus.req_ready;
`ifdef BEEP_SEQ_PREEMPT_EN
  assign urgent_push   = push && bus.req_urgent;
`else
  assign urgent_push   = 1'b0;
`endif
  assign tick          = (presc == PRESC_LAST);
  assign last_tick     = tick && (tick_cnt == 8'd1);

  beep_seq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (12)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (bus.flush),
    .replace (urgent_push),
    .push    (push),
    .pop     (pop),
    .wdata   ({bus.req_note, bus.req_dur}),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Flush and urgent pushes override the normal sequence and send the FSM back to IDLE
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load_play  = 1'b0;
    load_gap   = 1'b0;
    tone_en    = (state == ST_PLAY) && !is_rest(cur_note);
    if (bus.flush || urgent_push) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (cur_dur != 8'd0) begin
            load_play  = 1'b1;
            state_next = ST_PLAY;
          end else begin
            state_next = ST_IDLE;
          end
        end
        ST_PLAY: begin
          if (last_tick) begin
            if (GAP_TICKS == 0) begin
              state_next = ST_IDLE;
            end else begin
              load_gap   = 1'b1;
              state_next = ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (last_tick) state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Prescaler restarts on every PLAY/GAP entry so each segment lasts whole ticks exactly
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc    <= '0;
      tick_cnt <= '0;
      cur_note <= NOTE_REST;
      cur_dur  <= '0;
      period_q <= '0;
    end else begin
      if (pop) {cur_note, cur_dur} <= fifo_rdata;
      if (load_play || load_gap) begin
        presc    <= '0;
        tick_cnt <= load_play ? cur_dur : GAP_COUNT;
      end else if ((state == ST_PLAY) || (state == ST_GAP)) begin
        if (tick) begin
          presc    <= '0;
          tick_cnt <= tick_cnt - 8'd1;
        end else begin
          presc    <= presc + PRESC_W'(1);
        end
      end
      if (load_play && !is_rest(cur_note)) period_q <= NOTE_PERIOD[cur_note];
    end
  end

  assign bus.tone_en     = tone_en;
  assign bus.tone_period = period_q;
  assign bus.busy        = (state != ST_IDLE) || !fifo_empty;
  assign bus.fifo_level  = fifo_level;

endmodule

// File: tb/tb_beep_sequencer.sv
// Self-checking bench for beep_sequencer: directed scenarios plus random traffic,
// compared every cycle against a timeline model of queued notes.
module tb_beep_sequencer;
  import beep_seq_pkg::*;

  localparam int TICK_CYCLES = 10;
  localparam int FIFO_DEPTH  = 4;
  localparam int GAP_TICKS   = 2;

  typedef struct packed {
    logic [3:0] note;
    logic [7:0] dur;
  } req_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  beep_seq_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

  beep_sequencer #(
    .TICK_CYCLES (TICK_CYCLES),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .GAP_TICKS   (GAP_TICKS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of pending notes and the position inside the current note's
  // timeline (1 load cycle, dur*TICK sounding cycles, then GAP*TICK silent cycles)
  req_t        q[$];
  bit          m_active;
  int          m_t;
  int          m_len;
  req_t        m_cur;
  logic [31:0] m_period;
  bit          m_accepted;

  int n_vec;
  int n_miss;
  int edge_no;
  int first_rise;
  int high_cnt;
  int last_busy;
  bit prev_tone;

  function automatic logic [31:0] ref_period(input logic [3:0] code);
    case (code)
      4'd1:    return 32'd191113;
      4'd2:    return 32'd170262;
      4'd3:    return 32'd151686;
      4'd4:    return 32'd143173;
      4'd5:    return 32'd127551;
      4'd6:    return 32'd113636;
      4'd7:    return 32'd101239;
      4'd8:    return 32'd100000;
      4'd9:    return 32'd50000;
      4'd10:   return 32'd25000;
      4'd11:   return 32'd12500;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit ref_is_rest(input logic [3:0] code);
    return (code == 4'd0) || (code >= 4'd12);
  endfunction

  function automatic bit m_ready();
    if (rst !== 1'b1) return 1'b1;
    return (q.size() < FIFO_DEPTH) && (bus.flush !== 1'b1);
  endfunction

  function automatic void model_reset();
    q.delete();
    m_active = 1'b0;
    m_t      = 0;
    m_period = 32'd0;
  endfunction

  function automatic void model_edge();
    bit   accept;
    bit   urg;
    req_t r;
    accept = (bus.req_valid === 1'b1) && m_ready();
    urg    = 1'b0;
`ifdef BEEP_SEQ_PREEMPT_EN
    urg    = (bus.req_urgent === 1'b1);
`endif
    r.note     = bus.req_note;
    r.dur      = bus.req_dur;
    m_accepted = accept;
    if (bus.flush === 1'b1) begin
      q.delete();
      m_active = 1'b0;
      return;
    end
    if (accept && urg) begin
      q.delete();
      q.push_back(r);
      m_active = 1'b0;
      return;
    end
    if (m_active) begin
      m_t++;
      if (m_t == 1 && m_cur.dur != 8'd0 && !ref_is_rest(m_cur.note))
        m_period = ref_period(m_cur.note);
      if (m_t == m_len) m_active = 1'b0;
    end else if (q.size() > 0) begin
      m_cur    = q.pop_front();
      m_active = 1'b1;
      m_t      = 0;
      m_len    = (m_cur.dur == 8'd0) ? 1 : 1 + (int'(m_cur.dur) + GAP_TICKS) * TICK_CYCLES;
    end
    if (accept) q.push_back(r);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_output();
    bit exp_tone;
    exp_tone = m_active && (m_t >= 1) && (m_t <= int'(m_cur.dur) * TICK_CYCLES)
               && !ref_is_rest(m_cur.note);
    chk("tone_en",     32'(bus.tone_en),    32'(exp_tone));
    chk("tone_period", bus.tone_period,     m_period);
    chk("busy",        32'(bus.busy),       32'(m_active || (q.size() > 0)));
    chk("fifo_level",  32'(bus.fifo_level), 32'(q.size()));
    chk("req_ready",   32'(bus.req_ready),  32'(m_ready()));
  endtask

  task automatic apply_stimulus(input logic valid, input logic [3:0] note, input logic [7:0] dur,
                                input logic fl, input logic urg);
    bus.req_valid = valid;
    bus.req_note  = note;
    bus.req_dur   = dur;
    bus.flush     = fl;
`ifdef BEEP_SEQ_PREEMPT_EN
    bus.req_urgent = urg;
`else
    if (urg) bus.req_valid = valid;
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    edge_no++;
    @(negedge clk);
    check_output();
    if (bus.tone_en === 1'b1) begin
      high_cnt++;
      if (!prev_tone && first_rise < 0) first_rise = edge_no;
    end
    prev_tone = (bus.tone_en === 1'b1);
    if (bus.busy === 1'b1) last_busy = edge_no;
  endtask

  task automatic begin_measure();
    edge_no    = 0;
    first_rise = -1;
    high_cnt   = 0;
    last_busy  = 0;
    prev_tone  = (bus.tone_en === 1'b1);
  endtask

  task automatic run_until_idle(input string tag, input int max_steps);
    for (int i = 0; i < max_steps && (m_active || q.size() != 0); i++) step();
    chk({tag, "_drained"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    model_reset();
    apply_stimulus(1'b0, 4'd0, 8'd0, 1'b1, 1'b0);

    $display("[TB] reset values");
    repeat (3) @(negedge clk);
    check_output();
    rst = 1'b1;
    bus.flush = 1'b0;
    step();

    $display("[TB] single note");
    begin_measure();
    apply_stimulus(1'b1, 4'd8, 8'd3, 1'b0, 1'b0);
    step();
    apply_stimulus(1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    run_until_idle("single", 100);
    chk("single_latency", 32'(first_rise), 32'd3);
    chk("single_high_cycles", 32'(high_cnt), 32'd30);
    chk("single_busy_end", 32'(last_busy + 1), 32'd53);

    $display("[TB] back-pressure");
    begin_measure();
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b1, 4'(i + 1), 8'd1, 1'b0, 1'b0);
      step();
    end
    chk("bp_level_full", 32'(bus.fifo_level), 32'd4);
    chk("bp_ready_low", 32'(bus.req_ready), 32'd0);
    apply_stimulus(1'b1, 4'd6, 8'd1, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      step();
      if (m_accepted) break;
    end
    chk("bp_accept_edge", 32'(edge_no), 32'd35);
    chk("bp_level_after", 32'(bus.fifo_level), 32'd4);
    apply_stimulus(1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    run_until_idle("bp", 400);

    $display("[TB] rest and zero duration");
    begin_measure();
    apply_stimulus(1'b1, 4'd0, 8'd2, 1'b0, 1'b0);
    step();
    apply_stimulus(1'b1, 4'd9, 8'd0, 1'b0, 1'b0);
    step();
    apply_stimulus(1'b1, 4'd10, 8'd1, 1'b0, 1'b0);
    step();
    apply_stimulus(1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    run_until_idle("rest", 200);
    chk("rest_first_rise", 32'(first_rise), 32'd47);
    chk("rest_high_cycles", 32'(high_cnt), 32'd10);
    chk("rest_busy_end", 32'(last_busy + 1), 32'd77);

    $display("[TB] flush mid-note");
    begin_measure();
    apply_stimulus(1'b1, 4'd8, 8'd5, 1'b0, 1'b0);
    step();
    apply_stimulus(1'b1, 4'd1, 8'd1, 1'b0, 1'b0);
    step();
    apply_stimulus(1'b1, 4'd2, 8'd1, 1'b0, 1'b0);
    step();
    apply_stimulus(1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    repeat (5) step();
    chk("flush_pre_level", 32'(bus.fifo_level), 32'd2);
    chk("flush_pre_tone", 32'(bus.tone_en), 32'd1);
    apply_stimulus(1'b1, 4'd3, 8'd1, 1'b1, 1'b0);
    #1;
    chk("flush_ready", 32'(bus.req_ready), 32'd0);
    step();
    chk("flush_tone_off", 32'(bus.tone_en), 32'd0);
    chk("flush_level", 32'(bus.fifo_level), 32'd0);
    chk("flush_idle", 32'(bus.busy), 32'd0);
    apply_stimulus(1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    repeat (3) step();
    chk("flush_push_refused", 32'(bus.fifo_level), 32'd0);

    $display("[TB] reset mid-note");
    begin_measure();
    apply_stimulus(1'b1, 4'd9, 8'd4, 1'b0, 1'b0);
    step();
    apply_stimulus(1'b1, 4'd1, 8'd1, 1'b0, 1'b0);
    step();
    apply_stimulus(1'b1, 4'd2, 8'd1, 1'b0, 1'b0);
    step();
    apply_stimulus(1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    repeat (4) step();
    chk("rstmid_pre_tone", 32'(bus.tone_en), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rstmid_tone", 32'(bus.tone_en), 32'd0);
    chk("rstmid_busy", 32'(bus.busy), 32'd0);
    chk("rstmid_level", 32'(bus.fifo_level), 32'd0);
    chk("rstmid_period", bus.tone_period, 32'd0);
    chk("rstmid_ready", 32'(bus.req_ready), 32'd1);
    model_reset();
    @(negedge clk);
    check_output();
    rst = 1'b1;
    repeat (5) step();
    chk("rstmid_after_idle", 32'(bus.busy), 32'd0);

`ifdef BEEP_SEQ_PREEMPT_EN
    $display("[TB] urgent preemption");
    apply_stimulus(1'b1, 4'd8, 8'd20, 1'b0, 1'b0);
    step();
    for (int i = 1; i <= 3; i++) begin
      apply_stimulus(1'b1, 4'(i), 8'd1, 1'b0, 1'b0);
      step();
    end
    apply_stimulus(1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    repeat (3) step();
    chk("urg_pre_level", 32'(bus.fifo_level), 32'd3);
    apply_stimulus(1'b1, 4'd11, 8'd2, 1'b0, 1'b1);
    begin_measure();
    step();
    chk("urg_abort_tone", 32'(bus.tone_en), 32'd0);
    chk("urg_level", 32'(bus.fifo_level), 32'd1);
    apply_stimulus(1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    run_until_idle("urg", 200);
    chk("urg_rise_edge", 32'(first_rise), 32'd3);
    chk("urg_high_cycles", 32'(high_cnt), 32'd20);
`endif

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      apply_stimulus($urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)),
                     8'($urandom_range(0, 3)), $urandom_range(0, 63) == 0,
                     $urandom_range(0, 31) == 0);
      step();
    end
    apply_stimulus(1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    run_until_idle("random", 400);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
